// File: rtl/ppu_sprite_sched_if.sv
// Bus bundle between the sprite scheduler, OAM/pattern memory and the sprite generator array.
interface ppu_sprite_sched_if;
  localparam int unsigned OAM_AW = 6;
  localparam int unsigned PAT_AW = 12;

  logic              line_start;
  logic [7:0]        next_y;
  logic [OAM_AW-1:0] oam_addr;
  logic [31:0]       oam_data;
  logic [PAT_AW-1:0] pat_addr;
  logic [7:0]        pat_data;
  logic [7:0]        spgen_load;
  logic [7:0]        spgen_xpos;
  logic [7:0]        spgen_attr;
  logic [7:0]        spgen_line0;
  logic [7:0]        spgen_line1;
  logic              busy;
  logic              done;
  logic              overflow;

  // Scheduler side
  modport master (
    input  line_start, next_y, oam_data, pat_data,
    output oam_addr, pat_addr, spgen_load, spgen_xpos, spgen_attr,
           spgen_line0, spgen_line1, busy, done, overflow
  );

  // Memory / generator / line-timing side
  modport slave (
    output line_start, next_y, oam_data, pat_data,
    input  oam_addr, pat_addr, spgen_load, spgen_xpos, spgen_attr,
           spgen_line0, spgen_line1, busy, done, overflow
  );
endinterface

// File: rtl/ppu_sprite_sched.sv
// Per-scanline sprite scheduler: scans OAM for sprites on next_y, keeps the first 8,
// fetches both pattern planes per slot and loads the 8 sprite generators in turn.
module ppu_sprite_sched #(
  parameter int unsigned OAM_ENTRIES = 64,
  parameter int unsigned SPRITE_H    = 8
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  ppu_sprite_sched_if.master bus
);

  localparam int unsigned AW     = $clog2(OAM_ENTRIES);
  localparam int unsigned CW     = $clog2(OAM_ENTRIES + 1);
  localparam int unsigned SLOTS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVAL  = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
    logic [2:0] row;
  } slot_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    fs_q, fs_d;
  logic [1:0]    ph_q, ph_d;
  logic [3:0]    count_q, count_d;
  logic [7:0]    ny_q, ny_d;
  logic          ovf_q, ovf_d;

  slot_t         slot_q  [SLOTS];
  slot_t         slot_d  [SLOTS];
  logic [7:0]    line0_q [SLOTS];
  logic [7:0]    line0_d [SLOTS];
  logic [7:0]    line1_q [SLOTS];
  logic [7:0]    line1_d [SLOTS];

  logic [AW-1:0] oam_addr_q, oam_addr_d;
  logic [11:0]   pat_addr_q, pat_addr_d;
  logic [7:0]    load_q, load_d;
  logic [7:0]    xpos_q, xpos_d;
  logic [7:0]    attr_q, attr_d;
  logic [7:0]    l0_q, l0_d;
  logic [7:0]    l1_q, l1_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    oam_y, oam_tile, oam_attr, oam_x;
  logic [7:0]    diff;
  logic          hit;
  logic [2:0]    row;

  logic          pa_en;
  logic [2:0]    pa_idx;
  logic          pa_plane;
  logic          ld_en;
  logic [2:0]    ld_idx;

  // Decode the OAM entry returned this cycle and test it against the latched scanline
  always_comb begin
    oam_y    = bus.oam_data[31:24];
    oam_tile = bus.oam_data[23:16];
    oam_attr = bus.oam_data[15:8];
    oam_x    = bus.oam_data[7:0];
    diff     = ny_q - oam_y;
    hit      = (oam_y != 8'hFF) && (diff < 8'(SPRITE_H));
    row      = oam_attr[7] ? (3'(SPRITE_H - 1) - 3'(diff)) : 3'(diff);
  end

  // Next-state, slot table updates and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fs_d       = fs_q;
    ph_d       = ph_q;
    count_d    = count_q;
    ny_d       = ny_q;
    ovf_d      = ovf_q;
    slot_d     = slot_q;
    line0_d    = line0_q;
    line1_d    = line1_q;
    oam_addr_d = '0;
    pat_addr_d = '0;
    load_d     = '0;
    xpos_d     = '0;
    attr_d     = '0;
    l0_d       = '0;
    l1_d       = '0;
    pa_en      = 1'b0;
    pa_idx     = '0;
    pa_plane   = 1'b0;
    ld_en      = 1'b0;
    ld_idx     = '0;

    case (state_q)
      IDLE: begin
        if (bus.line_start) begin
          ny_d    = bus.next_y;
          count_d = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          for (int i = 0; i < SLOTS; i++) begin
            slot_d[i]  = '0;
            line0_d[i] = '0;
            line1_d[i] = '0;
          end
          state_d = EVAL;
        end
      end

      EVAL: begin
        // Entry k-1 is on oam_data at scan step k; step 0 only primes the read
        if (cnt_q != '0 && hit) begin
          if (count_q < 4'(SLOTS)) begin
            slot_d[count_q[2:0]] = '{tile: oam_tile, attr: oam_attr, x: oam_x, row: row};
            count_d              = count_q + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (cnt_q == CW'(OAM_ENTRIES)) begin
          state_d  = FETCH;
          cnt_d    = '0;
          fs_d     = '0;
          ph_d     = '0;
          pa_en    = 1'b1;
          pa_idx   = '0;
          pa_plane = 1'b0;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          oam_addr_d = AW'(cnt_q + CW'(1));
        end
      end

      FETCH: begin
        case (ph_q)
          2'd0: begin
            pa_en    = 1'b1;
            pa_idx   = fs_q;
            pa_plane = 1'b1;
            ph_d     = 2'd1;
          end
          2'd1: begin
            if ({1'b0, fs_q} < count_q) line0_d[fs_q] = bus.pat_data;
            ph_d = 2'd2;
          end
          default: begin
            if ({1'b0, fs_q} < count_q) line1_d[fs_q] = bus.pat_data;
            ph_d = 2'd0;
            if (fs_q == 3'(SLOTS - 1)) begin
              state_d = LOAD;
              fs_d    = '0;
              ld_en   = 1'b1;
              ld_idx  = '0;
            end else begin
              fs_d     = fs_q + 3'd1;
              pa_en    = 1'b1;
              pa_idx   = fs_q + 3'd1;
              pa_plane = 1'b0;
            end
          end
        endcase
      end

      LOAD: begin
        if (fs_q == 3'(SLOTS - 1)) begin
          state_d = DONE;
        end else begin
          fs_d   = fs_q + 3'd1;
          ld_en  = 1'b1;
          ld_idx = fs_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pattern address for the next fetch step, from the slot table as it will be next cycle
    if (pa_en) begin
      pat_addr_d = {slot_d[pa_idx].tile, pa_plane, slot_d[pa_idx].row};
    end

    // Load bus contents for the next slot; unfilled slots present as empty
    if (ld_en) begin
      load_d = 8'd1 << ld_idx;
      if ({1'b0, ld_idx} < count_d) begin
        xpos_d = slot_d[ld_idx].x;
        attr_d = slot_d[ld_idx].attr;
        l0_d   = line0_d[ld_idx];
        l1_d   = line1_d[ld_idx];
      end else begin
        xpos_d = 8'hFF;
      end
    end

    busy_d = (state_d == EVAL) || (state_d == FETCH) || (state_d == LOAD);
    done_d = (state_d == DONE);
  end

  // State, slot table and output registers
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fs_q       <= '0;
      ph_q       <= '0;
      count_q    <= '0;
      ny_q       <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i]  <= '0;
        line0_q[i] <= '0;
        line1_q[i] <= '0;
      end
      oam_addr_q <= '0;
      pat_addr_q <= '0;
      load_q     <= '0;
      xpos_q     <= '0;
      attr_q     <= '0;
      l0_q       <= '0;
      l1_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fs_q       <= fs_d;
      ph_q       <= ph_d;
      count_q    <= count_d;
      ny_q       <= ny_d;
      ovf_q      <= ovf_d;
      slot_q     <= slot_d;
      line0_q    <= line0_d;
      line1_q    <= line1_d;
      oam_addr_q <= oam_addr_d;
      pat_addr_q <= pat_addr_d;
      load_q     <= load_d;
      xpos_q     <= xpos_d;
      attr_q     <= attr_d;
      l0_q       <= l0_d;
      l1_q       <= l1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.oam_addr    = oam_addr_q;
  assign bus.pat_addr    = pat_addr_q;
  assign bus.spgen_load  = load_q;
  assign bus.spgen_xpos  = xpos_q;
  assign bus.spgen_attr  = attr_q;
  assign bus.spgen_line0 = l0_q;
  assign bus.spgen_line1 = l1_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_ppu_sprite_sched.sv
// Directed bench for ppu_sprite_sched: OAM/pattern memory models plus a table of scanlines.
module tb_ppu_sprite_sched;

  typedef struct {
    int                    setup;
    logic [7:0]            ny;
    logic [7:0][6:0]       eidx;   // expected OAM index per slot, 7'h7F = empty
    logic [7:0][2:0]       erow;   // expected pattern row per slot
    logic                  eovf;
    logic                  stray;  // throw extra line_start pulses while busy
  } vec_t;

  logic clk_25mhz = 1'b0;
  logic rst_n     = 1'b0;

  ppu_sprite_sched_if bus();

  ppu_sprite_sched #(.OAM_ENTRIES(64), .SPRITE_H(8)) dut (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  logic [31:0] oam [64];
  logic [7:0]  pat [4096];

  // One-cycle-latency OAM and pattern memories
  always @(posedge clk_25mhz) begin
    bus.oam_data <= oam[bus.oam_addr];
    bus.pat_data <= pat[bus.pat_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setup_oam(input int id);
    for (int i = 0; i < 64; i++) oam[i] = {8'hFF, 8'(i), 8'h5A, 8'(i + 3)};
    case (id)
      1: oam[3] = {8'd8, 8'd5, 8'h01, 8'd20};
      2: oam[3] = {8'd8, 8'd5, 8'h81, 8'd20};
      3: for (int i = 0; i < 10; i++) oam[i] = {8'd10, 8'(16 + i), 8'(i), 8'(i * 10 + 1)};
      4: oam[5] = {8'd250, 8'd9, 8'h02, 8'd77};
      5: oam[5] = {8'd251, 8'd9, 8'h02, 8'd77};
      6: begin
        oam[1]  = {8'd100, 8'd3, 8'h80, 8'hFF};
        oam[10] = {8'd108, 8'd6, 8'h00, 8'd30};
        oam[63] = {8'd95,  8'd4, 8'h10, 8'd200};
      end
      7: for (int i = 56; i < 64; i++)
           oam[i] = {8'd12, 8'(i), (i == 60) ? 8'h80 : 8'(i), 8'(i)};
      default: ;
    endcase
  endtask

  function automatic logic [39:0] exp_slot(input vec_t v, input int s);
    logic [6:0]  i;
    logic [7:0]  t;
    logic [2:0]  r;
    logic [31:0] e;
    i = v.eidx[s];
    if (i == 7'h7F) return {8'(1 << s), 8'hFF, 8'h00, 8'h00, 8'h00};
    e = oam[i[5:0]];
    t = e[23:16];
    r = v.erow[s];
    return {8'(1 << s), e[7:0], e[15:8], pat[{t, 1'b0, r}], pat[{t, 1'b1, r}]};
  endfunction

  function automatic logic [11:0] exp_pa0(input vec_t v);
    logic [6:0]  i;
    logic [31:0] e;
    i = v.eidx[0];
    if (i == 7'h7F) return 12'h000;
    e = oam[i[5:0]];
    return {e[23:16], 1'b0, v.erow[0]};
  endfunction

  function automatic logic [60:0] all_outs();
    return {bus.oam_addr, bus.pat_addr, bus.spgen_load, bus.spgen_xpos, bus.spgen_attr,
            bus.spgen_line0, bus.spgen_line1, bus.busy, bus.done, bus.overflow};
  endfunction

  // Run one full scanline schedule; cycle k counts from the line_start acceptance cycle
  task automatic run_line(input vec_t v, input int id);
    int         dones;
    int         done_k;
    int         busy_err;
    int         spur;
    logic       ovf_done;
    logic [11:0] pa0;
    dones = 0; done_k = -1; busy_err = 0; spur = 0; ovf_done = 1'bx;
    setup_oam(v.setup);
    pa0 = exp_pa0(v);
    @(negedge clk_25mhz);
    bus.next_y     = v.ny;
    bus.line_start = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk_25mhz);
      bus.line_start = 1'b0;
      if (v.stray && (k == 10 || k == 70 || k == 95 || k == 98)) begin
        bus.line_start = 1'b1;
        bus.next_y     = 8'd50;
      end
      if (bus.busy !== ((k >= 1) && (k <= 97))) busy_err++;
      if (k == 1)  chk($sformatf("v%0d oam_addr_k0", id), 64'(bus.oam_addr), 64'd0);
      if (k == 64) chk($sformatf("v%0d oam_addr_k63", id), 64'(bus.oam_addr), 64'd63);
      if (k == 66) chk($sformatf("v%0d pat_addr_s0p0", id), 64'(bus.pat_addr), 64'(pa0));
      if (k == 67) chk($sformatf("v%0d pat_addr_s0p1", id), 64'(bus.pat_addr), 64'(pa0 | 12'h008));
      if (k >= 90 && k <= 97) begin
        chk($sformatf("v%0d load_slot%0d", id, k - 90),
            64'({bus.spgen_load, bus.spgen_xpos, bus.spgen_attr, bus.spgen_line0, bus.spgen_line1}),
            64'(exp_slot(v, k - 90)));
      end else if ({bus.spgen_load, bus.spgen_xpos, bus.spgen_attr,
                    bus.spgen_line0, bus.spgen_line1} != 40'd0) begin
        spur++;
      end
      if (bus.done === 1'b1) begin
        dones++;
        done_k   = k;
        ovf_done = bus.overflow;
      end
    end
    chk($sformatf("v%0d done_count", id), 64'(dones), 64'd1);
    chk($sformatf("v%0d done_cycle", id), 64'(done_k), 64'd98);
    chk($sformatf("v%0d overflow_at_done", id), 64'(ovf_done), 64'(v.eovf));
    chk($sformatf("v%0d overflow_held", id), 64'(bus.overflow), 64'(v.eovf));
    chk($sformatf("v%0d busy_window_errs", id), 64'(busy_err), 64'd0);
    chk($sformatf("v%0d bus_idle_errs", id), 64'(spur), 64'd0);
  endtask

  initial begin
    int act;
    bus.line_start = 1'b0;
    bus.next_y     = 8'd0;
    setup_oam(0);
    for (int a = 0; a < 4096; a++) pat[a] = 8'(a * 13 + 7);
    pat[{8'd5, 1'b0, 3'd2}] = 8'hF0;
    pat[{8'd5, 1'b1, 3'd2}] = 8'h0F;
    pat[{8'd5, 1'b0, 3'd5}] = 8'h3C;
    pat[{8'd5, 1'b1, 3'd5}] = 8'hC3;

    for (int i = 0; i < 9; i++) begin
      vt[i].setup = 0;
      vt[i].ny    = 8'd0;
      vt[i].eidx  = {8{7'h7F}};
      vt[i].erow  = '0;
      vt[i].eovf  = 1'b0;
      vt[i].stray = 1'b0;
    end
    vt[0].setup = 0; vt[0].ny = 8'd10;
    vt[1].setup = 1; vt[1].ny = 8'd10; vt[1].eidx[0] = 7'd3; vt[1].erow[0] = 3'd2;
    vt[2].setup = 2; vt[2].ny = 8'd10; vt[2].eidx[0] = 7'd3; vt[2].erow[0] = 3'd5;
    vt[3].setup = 3; vt[3].ny = 8'd12; vt[3].eovf = 1'b1;
    for (int s = 0; s < 8; s++) begin vt[3].eidx[s] = 7'(s); vt[3].erow[s] = 3'd2; end
    vt[4].setup = 4; vt[4].ny = 8'd2;
    vt[5].setup = 5; vt[5].ny = 8'd2; vt[5].eidx[0] = 7'd5; vt[5].erow[0] = 3'd7;
    vt[6].setup = 6; vt[6].ny = 8'd100;
    vt[6].eidx[0] = 7'd1;  vt[6].erow[0] = 3'd7;
    vt[6].eidx[1] = 7'd63; vt[6].erow[1] = 3'd5;
    vt[7].setup = 7; vt[7].ny = 8'd12;
    for (int s = 0; s < 8; s++) begin vt[7].eidx[s] = 7'(56 + s); vt[7].erow[s] = 3'd0; end
    vt[7].erow[4] = 3'd7;
    vt[8] = vt[1]; vt[8].stray = 1'b1;

    // Reset state
    repeat (3) @(negedge clk_25mhz);
    chk("reset_outputs", 64'(all_outs()), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_25mhz);
    chk("idle_outputs", 64'(all_outs()), 64'd0);

    for (int i = 0; i < 8; i++) run_line(vt[i], i);

    // Reset in the middle of FETCH aborts the line with no later strobes
    setup_oam(1);
    @(negedge clk_25mhz);
    bus.next_y     = 8'd10;
    bus.line_start = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk_25mhz);
      bus.line_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'(all_outs()), 64'd0);
    repeat (2) @(negedge clk_25mhz);
    rst_n = 1'b1;
    act = 0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk_25mhz);
      if (bus.spgen_load != 8'd0 || bus.done || bus.busy) act++;
    end
    chk("postreset_activity", 64'(act), 64'd0);
    chk("postreset_outputs", 64'(all_outs()), 64'd0);

    // Fresh line after reset with line_start pulses thrown in while busy
    run_line(vt[8], 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
